// File: rtl/cpu_bus_spi_bridge_if.sv
// CPU-bus / SPI-controller signal bundle for cpu_bus_spi_bridge.
// slave = bridge side, master = CPU plus flash-controller side.
interface cpu_bus_spi_bridge_if;
  logic        i_E;
  logic        i_Q;
  logic [15:0] i_ADDRESS_BUS;
  logic [7:0]  i_DataBus;
  logic        i_RW;
  logic [7:0]  i_spi_data;
  logic        i_MemoryReady;
  logic        o_spi_ce;
  logic [15:0] o_spi_address;
  logic [7:0]  o_spi_wdata;
  logic        o_spi_rw;
  logic [7:0]  o_DataBus;
  logic        o_data_oe;
  logic        o_MRDY;
  logic        o_timeout;

  modport slave (
    input  i_E, i_Q, i_ADDRESS_BUS, i_DataBus, i_RW, i_spi_data, i_MemoryReady,
    output o_spi_ce, o_spi_address, o_spi_wdata, o_spi_rw, o_DataBus, o_data_oe,
           o_MRDY, o_timeout
  );

  modport master (
    output i_E, i_Q, i_ADDRESS_BUS, i_DataBus, i_RW, i_spi_data, i_MemoryReady,
    input  o_spi_ce, o_spi_address, o_spi_wdata, o_spi_rw, o_DataBus, o_data_oe,
           o_MRDY, o_timeout
  );
endinterface

// File: rtl/cpu_bus_spi_bridge.sv
// 6809 E/Q bus front-end for spi_flash_controller: decode, stretch via MRDY, return read data.
// Optional one-entry read cache is built when BRIDGE_READ_CACHE_EN is defined.
//
// state | meaning
// IDLE  | waiting for a Q rise (E low) that hits the flash window
// REQ   | spi_ce held, MRDY low, waiting for a ready edge or timeout
// DONE  | result returned, data_oe driven for reads until E falls
module cpu_bus_spi_bridge #(
  parameter logic [15:0] WIN_BASE       = 16'h0000,
  parameter logic [15:0] WIN_MASK       = 16'hC000,
  parameter int          SYNC_STAGES    = 2,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input logic                 clk,
  input logic                 reset,
  cpu_bus_spi_bridge_if.slave bus
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] e_sync_q, q_sync_q;
  logic                   e_prev_q, q_prev_q, rdy_prev_q, e_fell_q;
  logic [CW-1:0]          tmo_cnt_q;
  logic                   spi_ce_q, spi_rw_q, oe_q, mrdy_q, timeout_q;
  logic [15:0]            spi_addr_q;
  logic [7:0]             spi_wdata_q, dbus_q;
`ifdef BRIDGE_READ_CACHE_EN
  logic                   cache_vld_q;
  logic [15:0]            cache_addr_q;
  logic [7:0]             cache_data_q;
`endif

  logic e_s, q_s, cycle_start, e_fall, rdy_rise, win_hit, tc_hit, discard;

  assign e_s         = e_sync_q[SYNC_STAGES-1];
  assign q_s         = q_sync_q[SYNC_STAGES-1];
  assign cycle_start = q_s & ~q_prev_q & ~e_s;
  assign e_fall      = ~e_s & e_prev_q;
  // Edge rather than level, so a ready left high from a previous request is ignored.
  assign rdy_rise    = bus.i_MemoryReady & ~rdy_prev_q;
  assign win_hit     = (bus.i_ADDRESS_BUS & WIN_MASK) == (WIN_BASE & WIN_MASK);
  assign tc_hit      = (tmo_cnt_q == TC_LAST);
  assign discard     = e_fell_q | e_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      e_sync_q    <= '0;
      q_sync_q    <= '0;
      e_prev_q    <= 1'b0;
      q_prev_q    <= 1'b0;
      rdy_prev_q  <= 1'b0;
      e_fell_q    <= 1'b0;
      tmo_cnt_q   <= '0;
      spi_ce_q    <= 1'b0;
      spi_addr_q  <= '0;
      spi_wdata_q <= '0;
      spi_rw_q    <= 1'b1;
      dbus_q      <= '0;
      oe_q        <= 1'b0;
      mrdy_q      <= 1'b1;
      timeout_q   <= 1'b0;
`ifdef BRIDGE_READ_CACHE_EN
      cache_vld_q  <= 1'b0;
      cache_addr_q <= '0;
      cache_data_q <= '0;
`endif
    end else begin
      e_sync_q   <= {e_sync_q[SYNC_STAGES-2:0], bus.i_E};
      q_sync_q   <= {q_sync_q[SYNC_STAGES-2:0], bus.i_Q};
      e_prev_q   <= e_s;
      q_prev_q   <= q_s;
      rdy_prev_q <= bus.i_MemoryReady;

      case (state_q)
        IDLE: begin
          if (cycle_start && win_hit) begin
            spi_addr_q  <= bus.i_ADDRESS_BUS;
            spi_wdata_q <= bus.i_DataBus;
            spi_rw_q    <= bus.i_RW;
            e_fell_q    <= 1'b0;
`ifdef BRIDGE_READ_CACHE_EN
            if (bus.i_RW && cache_vld_q && (cache_addr_q == bus.i_ADDRESS_BUS)) begin
              dbus_q  <= cache_data_q;
              oe_q    <= 1'b1;
              state_q <= DONE;
            end else begin
              if (!bus.i_RW) cache_vld_q <= 1'b0;
              spi_ce_q  <= 1'b1;
              mrdy_q    <= 1'b0;
              tmo_cnt_q <= '0;
              state_q   <= REQ;
            end
`else
            spi_ce_q  <= 1'b1;
            mrdy_q    <= 1'b0;
            tmo_cnt_q <= '0;
            state_q   <= REQ;
`endif
          end
        end

        REQ: begin
          if (e_fall) e_fell_q <= 1'b1;
          if (rdy_rise || tc_hit) begin
            spi_ce_q <= 1'b0;
            mrdy_q   <= 1'b1;
            if (rdy_rise) begin
              if (spi_rw_q && !discard) dbus_q <= bus.i_spi_data;
`ifdef BRIDGE_READ_CACHE_EN
              if (spi_rw_q) begin
                cache_vld_q  <= 1'b1;
                cache_addr_q <= spi_addr_q;
                cache_data_q <= bus.i_spi_data;
              end
`endif
            end else begin
              timeout_q <= 1'b1;
              if (!discard) dbus_q <= 8'hFF;
`ifdef BRIDGE_READ_CACHE_EN
              cache_vld_q <= 1'b0;
`endif
            end
            // CPU already left the cycle: nothing to drive, skip DONE.
            if (discard) begin
              state_q <= IDLE;
            end else begin
              oe_q    <= spi_rw_q;
              state_q <= DONE;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end

        DONE: begin
          if (e_fall) begin
            oe_q    <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_spi_ce      = spi_ce_q;
  assign bus.o_spi_address = spi_addr_q;
  assign bus.o_spi_wdata   = spi_wdata_q;
  assign bus.o_spi_rw      = spi_rw_q;
  assign bus.o_DataBus     = dbus_q;
  assign bus.o_data_oe     = oe_q;
  assign bus.o_MRDY        = mrdy_q;
  assign bus.o_timeout     = timeout_q;
endmodule

// File: tb/tb_cpu_bus_spi_bridge.sv
// Directed bench for cpu_bus_spi_bridge: transaction-level model of bus cycles, flash memory and cache.
module tb_cpu_bus_spi_bridge;
  localparam int SYNC = 2;
  localparam int TMO  = 4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_bus_spi_bridge_if bus();
  cpu_bus_spi_bridge dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem [0:65535];
  int          ce_count = 0;
  int          rdy_dly  = 0;
  bit          mon_en   = 0;
  logic [15:0] exp_addr = '0;
  logic        exp_rw   = 1'b1;
  logic [7:0]  exp_wd   = '0;
  logic [7:0]  m_dbus   = '0;
  bit          m_timeout = 0;
  bit          m_cache_vld = 0;
  logic [15:0] m_cache_addr = '0;
  logic [7:0]  m_cache_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Flash controller model: one request per spi_ce, ready after rdy_dly clocks (0 = never).
  initial begin
    int  waited;
    bit  in_req;
    logic [15:0] a;
    waited = 0;
    in_req = 0;
    a = '0;
    bus.i_MemoryReady = 1'b0;
    bus.i_spi_data    = 8'h00;
    forever begin
      @(negedge clk);
      if (!in_req && bus.o_spi_ce) begin
        in_req = 1;
        ce_count++;
        waited = 0;
        a = bus.o_spi_address;
        if (!bus.o_spi_rw) mem[a] = bus.o_spi_wdata;
      end else if (in_req) begin
        if (!bus.o_spi_ce) begin
          in_req = 0;
          bus.i_MemoryReady = 1'b0;
        end else begin
          waited++;
          if (rdy_dly != 0 && waited == rdy_dly) begin
            bus.i_spi_data    = mem[a];
            bus.i_MemoryReady = 1'b1;
          end
        end
      end
    end
  end

  // Continuous checks: latched request fields stable while spi_ce is up, oe only on reads.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mrdy_low_iff_ce", 32'(bus.o_MRDY), 32'(!bus.o_spi_ce));
      if (bus.o_spi_ce) begin
        chk("req_addr", 32'(bus.o_spi_address), 32'(exp_addr));
        chk("req_rw", 32'(bus.o_spi_rw), 32'(exp_rw));
        if (!exp_rw) chk("req_wdata", 32'(bus.o_spi_wdata), 32'(exp_wd));
      end
      if (bus.o_data_oe) chk("oe_only_on_read", 32'(bus.o_data_oe), 32'(exp_rw));
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ce"}, 32'(bus.o_spi_ce), 0);
    chk({tag, "_addr"}, 32'(bus.o_spi_address), 0);
    chk({tag, "_wdata"}, 32'(bus.o_spi_wdata), 0);
    chk({tag, "_rw"}, 32'(bus.o_spi_rw), 1);
    chk({tag, "_dbus"}, 32'(bus.o_DataBus), 0);
    chk({tag, "_oe"}, 32'(bus.o_data_oe), 0);
    chk({tag, "_mrdy"}, 32'(bus.o_MRDY), 1);
    chk({tag, "_timeout"}, 32'(bus.o_timeout), 0);
  endtask

  // One 6809 bus cycle. dly = controller ready delay (0 = never ready), e_early = CPU drops E mid-REQ.
  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw,
                           input int dly, input bit e_early);
    bit hit, use_cache, to, go_req;
    int ce0, low;
    logic [7:0] rd_val;
    hit       = ((a & 16'hC000) == 16'h0000);
    use_cache = hit && rw && m_cache_vld && (m_cache_addr == a);
    go_req    = hit && !use_cache;
    to        = go_req && (dly == 0);
    rd_val    = use_cache ? m_cache_data : mem[a];
    ce0       = ce_count;

    @(negedge clk);
    bus.i_ADDRESS_BUS = a;
    bus.i_DataBus     = d;
    bus.i_RW          = rw;
    bus.i_E           = 1'b0;
    bus.i_Q           = 1'b0;
    if (hit) begin
      exp_addr = a;
      exp_rw   = rw;
      exp_wd   = d;
    end
    rdy_dly = dly;
    @(negedge clk);
    bus.i_Q = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrdy_before_sync", 32'(bus.o_MRDY), 1);
    bus.i_E = 1'b1;
    bus.i_Q = 1'b0;
    @(negedge clk);
    if (go_req) begin
      chk("mrdy_fall_latency", 32'(bus.o_MRDY), 0);
      low = 0;
      while (bus.o_MRDY == 1'b0 && low < 5000) begin
        low++;
        if (e_early && low == 5) bus.i_E = 1'b0;
        @(negedge clk);
      end
      chk("stretch_len", 32'(low), to ? 32'(TMO) : 32'(dly + 1));
      chk("ce_after_stretch", 32'(bus.o_spi_ce), 0);
    end else begin
      chk("mrdy_no_drop", 32'(bus.o_MRDY), 1);
    end

    if (hit && !e_early) begin
      if (to) m_dbus = 8'hFF;
      else if (rw) m_dbus = rd_val;
    end
    if (to) m_timeout = 1;
`ifdef BRIDGE_READ_CACHE_EN
    if (go_req && rw && !to) begin
      m_cache_vld  = 1;
      m_cache_addr = a;
      m_cache_data = rd_val;
    end
    if (go_req && (!rw || to)) m_cache_vld = 0;
`endif
    chk("databus", 32'(bus.o_DataBus), 32'(m_dbus));
    chk("data_oe", 32'(bus.o_data_oe), 32'(hit && rw && !e_early));
    chk("timeout_flag", 32'(bus.o_timeout), 32'(m_timeout));
    repeat (3) @(negedge clk);
    chk("data_oe_hold", 32'(bus.o_data_oe), 32'(hit && rw && !e_early));
    bus.i_E = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    chk("data_oe_release", 32'(bus.o_data_oe), 0);
    chk("ce_pulses", 32'(ce_count - ce0), 32'(go_req));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ce0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8);
    mem[16'h3AAA] = 8'hFA;
    reset = 1'b1;
    bus.i_E = 1'b0;
    bus.i_Q = 1'b0;
    bus.i_ADDRESS_BUS = '0;
    bus.i_DataBus = '0;
    bus.i_RW = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst_held");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst_released");
    mon_en = 1;

    // read inside window, ready after 80 clocks
    cpu_cycle(16'h3AAA, 8'h00, 1'b1, 80, 0);
    chk("lit_read_data", 32'(bus.o_DataBus), 32'h00FA);
    chk("lit_read_addr", 32'(bus.o_spi_address), 32'h3AAA);
    chk("lit_read_rw", 32'(bus.o_spi_rw), 1);

    // write
    cpu_cycle(16'h3000, 8'hAA, 1'b0, 30, 0);
    chk("lit_write_data", 32'(bus.o_spi_wdata), 32'h00AA);
    chk("lit_write_rw", 32'(bus.o_spi_rw), 0);
    chk("lit_write_keeps_dbus", 32'(bus.o_DataBus), 32'h00FA);

    // window misses and window edges
    cpu_cycle(16'h8000, 8'h00, 1'b1, 10, 0);
    chk("lit_miss_addr_kept", 32'(bus.o_spi_address), 32'h3000);
    cpu_cycle(16'h4000, 8'h00, 1'b1, 10, 0);
    cpu_cycle(16'h3FFF, 8'h00, 1'b1, 1, 0);
    cpu_cycle(16'h0000, 8'h00, 1'b1, 5, 0);
    chk("lit_read_0000", 32'(bus.o_DataBus), 32'h0000);
    cpu_cycle(16'h3000, 8'h00, 1'b1, 7, 0);
    chk("lit_readback_3000", 32'(bus.o_DataBus), 32'h00AA);

    // CPU drops E while the request is in flight
    cpu_cycle(16'h1234, 8'h00, 1'b1, 20, 0);
    cpu_cycle(16'h1235, 8'h00, 1'b1, 20, 1);

    // controller never answers
    cpu_cycle(16'h2222, 8'h00, 1'b1, 0, 0);
    chk("lit_timeout_data", 32'(bus.o_DataBus), 32'h00FF);
    chk("lit_timeout_flag", 32'(bus.o_timeout), 1);
    cpu_cycle(16'h1000, 8'h33, 1'b0, 3, 0);
    chk("lit_timeout_sticky", 32'(bus.o_timeout), 1);

    // reset in the middle of REQ
    @(negedge clk);
    bus.i_ADDRESS_BUS = 16'h0123;
    bus.i_RW = 1'b1;
    exp_addr = 16'h0123;
    exp_rw = 1'b1;
    rdy_dly = 0;
    @(negedge clk);
    bus.i_Q = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_req_ce", 32'(bus.o_spi_ce), 1);
    #2 reset = 1'b1;
    #1 check_reset_vals("rst_mid_req");
    m_timeout = 0;
    m_dbus = '0;
    m_cache_vld = 0;
    bus.i_Q = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_vals("rst_mid_after");

    cpu_cycle(16'h3AAA, 8'h00, 1'b1, 12, 0);
    chk("lit_post_reset_read", 32'(bus.o_DataBus), 32'h00FA);

`ifdef BRIDGE_READ_CACHE_EN
    ce0 = ce_count;
    cpu_cycle(16'h3AAA, 8'h00, 1'b1, 12, 0);
    cpu_cycle(16'h3AAA, 8'h5C, 1'b0, 4, 0);
    cpu_cycle(16'h3AAA, 8'h00, 1'b1, 6, 0);
    chk("lit_cache_refetch_data", 32'(bus.o_DataBus), 32'h005C);
    chk("lit_cache_ce_total", 32'(ce_count - ce0), 2);
`else
    ce0 = ce_count;
    cpu_cycle(16'h3AAA, 8'h00, 1'b1, 12, 0);
    chk("lit_nocache_ce_total", 32'(ce_count - ce0), 1);
`endif

    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
